mem_dump: RTL
=============

# mem_dump

Hardware memory read-out engine: on a start command it reads a contiguous range of data-memory words through a synchronous read port and streams them out over a valid/ready interface. This is the hardware counterpart to how the processor bench preloads memories. The bench or a debug host uses it to extract data-memory contents from a running design without hierarchical references. It sits beside the processor's data memory on a dedicated read port.

## Interface
Parameters:
- ADDR_W, 10, word-address width of data memory
- DATA_W, 32, word width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle command; sampled only in IDLE
- base_addr  in  ADDR_W  first word address, captured on start
- count  in  ADDR_W+1  number of words to dump, captured on start; 0 is legal
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse at completion
- mem_rd_en  out  1  read strobe to data memory
- mem_rd_addr  out  ADDR_W  read word address
- mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en
- out_valid  out  1  stream word available
- out_ready  in  1  sink accepts word
- out_data  out  DATA_W  stream word
- out_addr  out  ADDR_W  address the word came from (0 for the checksum word)
- out_last  out  1  marks the final stream word

## Operation
- FSM states, in a shared enum: IDLE, READ, DRAIN, DONE.
- IDLE: on start, latch base_addr/count, clear the running checksum, and go to READ. If count==0, go to DONE instead.
- READ: issue one read per cycle while (fifo_count + inflight) < 2.
  - mem_rd_addr increments by 1 per issued read, wrapping modulo 2^ADDR_W.
  - After the count-th read is issued, go to DRAIN.
- DRAIN: wait until the FIFO is empty and nothing is in flight, then go to DONE.
- DONE: pulse done for one cycle, drop busy, and return to IDLE.
- Returned read data is pushed into a 2-entry FIFO together with its address. out_* is driven from the FIFO head.
- out_last is high on the final data word, or on the checksum word when the checksum feature is enabled.
- start while busy is ignored. count/base_addr changes after capture have no effect.
- Once asserted, out_valid holds, and out_data/out_addr/out_last stay stable, until out_ready. There is no combinational path from out_ready to out_valid.
- Reset at any time, including mid-dump, forces IDLE and empties the FIFO. Any in-flight read return is discarded.
- Reset values: busy=0, done=0, mem_rd_en=0, mem_rd_addr=0, out_valid=0, out_data=0, out_addr=0, out_last=0.

## Timing
- start sampled at edge 0: busy=1 and the first mem_rd_en both appear after edge 0.
- Data returns 1 cycle after each mem_rd_en. out_valid rises in the cycle after the data returns, i.e. 2 cycles after the first mem_rd_en.
- With out_ready held high, throughput is 1 word per cycle and a dump of N words completes in N+3 cycles from start to done.
- done pulses the cycle after the out_last handshake. For count==0, done pulses the cycle after start.
- Backpressure: at most 2 words are buffered. Reads stall so that the FIFO never overflows.

## Configuration
- MEM_DUMP_CHECKSUM_EN defined:
  - Keep a running 32-bit wrap-around sum of all data words.
  - After the last data word, emit one extra word: out_data=sum, out_addr=0, out_last=1.
  - For count==0, emit only the checksum word 0.
- Not defined: no checksum logic, and out_last is on the final data word.

## Structure
- Package mem_dump_pkg holds the state enum (mem_dump_state_e) and the FIFO depth constant (DUMP_FIFO_DEPTH=2).
- One sub-module, dump_fifo: a 2-entry synchronous FIFO carrying {last, addr, data}, with push/pop/count.

## Test plan
- base_addr=4, count=3, memory words 4..6 = 0x11,0x22,0x33, out_ready=1:
  - Stream is 0x11@4, 0x22@5, 0x33@6 with last on 0x33.
  - done at cycle 6 after start.
- count=0: no out_valid, and done pulses 1 cycle after start (checksum off).
- Same dump as the first case, with out_ready toggled 1,0,0,1,0,1: data order is preserved, values stay stable while stalled, and mem_rd_en never runs more than 2 words ahead.
- base_addr=2^ADDR_W-1, count=2: the addresses read are 1023 then 0.
- Reset asserted mid-dump after 1 word is accepted: all outputs take their reset values immediately. A following dump of 2 words is correct.
- MEM_DUMP_CHECKSUM_EN with the words 0xFFFFFFFF and 0x2: a third word 0x1 is emitted with out_last=1.

Source files
------------

// File: rtl/mem_dump_pkg.sv
// mem_dump_pkg: shared FSM encoding and FIFO sizing for the memory dump engine.
package mem_dump_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} mem_dump_state_e;
  localparam int DUMP_FIFO_DEPTH = 2;
endpackage

// File: rtl/dump_fifo.sv
// dump_fifo: small synchronous FIFO holding {last, addr, data} words for the dump stream.
// Storage is cleared on reset so the head reads as zero while idle.
module dump_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          valid,
  output logic [CW-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp, rp;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= inc(wp);
      end
      if (pop) rp <= inc(rp);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign dout  = mem[rp];
  assign valid = (count != '0);
endmodule

// File: rtl/mem_dump.sv
// mem_dump: reads a contiguous range of data-memory words and streams them over valid/ready.
// Define MEM_DUMP_CHECKSUM_EN to append a wrap-around sum word after the data.
module mem_dump
  import mem_dump_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
);
  localparam int EW = 1 + ADDR_W + DATA_W;
  localparam int CW = $clog2(DUMP_FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DUMP_FIFO_DEPTH);
`ifdef MEM_DUMP_CHECKSUM_EN
  localparam bit LAST_ON_DATA = 1'b0;
`else
  localparam bit LAST_ON_DATA = 1'b1;
`endif

  mem_dump_state_e   state, state_nx;
  logic [ADDR_W:0]   remain;
  logic [ADDR_W-1:0] rd_addr, pend_addr, push_addr;
  logic              rd_pend, pend_last, push, push_last, pop, drained, csum_todo;
  logic [DATA_W-1:0] push_data;
  logic [CW-1:0]     fifo_cnt;
  logic [CW:0]       credit;
  logic [EW-1:0]     head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Done once the FIFO empties this cycle with no read return or checksum still owed.
  assign drained = !rd_pend && !csum_todo &&
                   ((fifo_cnt == '0) || ((fifo_cnt == CW'(1)) && pop));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) begin
`ifdef MEM_DUMP_CHECKSUM_EN
        state_nx = (count == '0) ? DRAIN : READ;
`else
        state_nx = (count == '0) ? DONE : READ;
`endif
      end
      READ:    if (mem_rd_en && (remain == (ADDR_W+1)'(1))) state_nx = DRAIN;
      DRAIN:   if (drained) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A pop frees a slot this cycle, so a full-rate stream keeps one word in flight.
  always_comb begin
    busy      = (state == READ) || (state == DRAIN);
    done      = (state == DONE);
    credit    = {1'b0, fifo_cnt} + {{CW{1'b0}}, rd_pend} - {{CW{1'b0}}, pop};
    mem_rd_en = (state == READ) && (remain != '0) && (credit < {1'b0, FULL_CNT});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remain    <= '0;
      rd_addr   <= '0;
      rd_pend   <= 1'b0;
      pend_addr <= '0;
      pend_last <= 1'b0;
    end else begin
      rd_pend <= mem_rd_en;
      if (state == IDLE && start) begin
        remain  <= count;
        rd_addr <= base_addr;
      end else if (mem_rd_en) begin
        remain    <= remain - (ADDR_W+1)'(1);
        rd_addr   <= rd_addr + ADDR_W'(1);
        pend_addr <= rd_addr;
        pend_last <= LAST_ON_DATA && (remain == (ADDR_W+1)'(1));
      end
    end
  end

  assign mem_rd_addr = rd_addr;

`ifdef MEM_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  logic              sum_push;

  assign sum_push = csum_todo && (state == DRAIN) && !rd_pend && (fifo_cnt < FULL_CNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum       <= '0;
      csum_todo <= 1'b0;
    end else if (state == IDLE && start) begin
      sum       <= '0;
      csum_todo <= 1'b1;
    end else begin
      if (rd_pend)  sum       <= sum + mem_rd_data;
      if (sum_push) csum_todo <= 1'b0;
    end
  end

  assign push      = rd_pend || sum_push;
  assign push_data = rd_pend ? mem_rd_data : sum;
  assign push_addr = rd_pend ? pend_addr : '0;
  assign push_last = rd_pend ? pend_last : 1'b1;
`else
  assign csum_todo = 1'b0;
  assign push      = rd_pend;
  assign push_data = mem_rd_data;
  assign push_addr = pend_addr;
  assign push_last = pend_last;
`endif

  assign pop = out_valid && out_ready;

  dump_fifo #(.W(EW), .DEPTH(DUMP_FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({push_last, push_addr, push_data}),
    .pop   (pop),
    .dout  (head),
    .valid (out_valid),
    .count (fifo_cnt)
  );

  assign {out_last, out_addr, out_data} = head;
endmodule
